// File: rtl/collision_event_ctrl.sv
// Turns per-frame collision flag levels into game events: bonus pickup, scoring,
// bonus-sprite hiding, crash freeze and a blinking recovery window.
module collision_event_ctrl #(
  parameter logic [15:0] BONUS_POINTS   = 16'd100,
  parameter logic [7:0]  HIDE_FRAMES    = 8'd60,
  parameter logic [7:0]  CRASH_FRAMES   = 8'd45,
  parameter logic [7:0]  RECOVER_FRAMES = 8'd90
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [4:0]  game_states,
  input  logic        score_clear,
  output logic        bonus_pulse,
  output logic        bonus_visible,
  output logic        freeze,
  output logic        player_blink,
  output logic [15:0] score,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    StPlay    = 2'b00,
    StHide    = 2'b01,
    StCrash   = 2'b10,
    StRecover = 2'b11
  } state_e;

  // A zero duration behaves as a single frame.
  localparam logic [7:0] HideLoad    = (HIDE_FRAMES    == 8'd0) ? 8'd0 : HIDE_FRAMES    - 8'd1;
  localparam logic [7:0] CrashLoad   = (CRASH_FRAMES   == 8'd0) ? 8'd0 : CRASH_FRAMES   - 8'd1;
  localparam logic [7:0] RecoverLoad = (RECOVER_FRAMES == 8'd0) ? 8'd0 : RECOVER_FRAMES - 8'd1;

  state_e      r_state, w_state_d;
  logic [7:0]  r_fcnt, w_fcnt_d;
  logic        r_frame_tick;
  logic        r_visible, w_visible_d;
  logic        r_pulse, w_pulse_d;
  logic        r_freeze, r_blink;
  logic [15:0] r_score, w_score_d;
  logic [16:0] w_sum;
  logic        w_bonus, w_crash;
  logic        w_unused_flags;

  assign w_bonus        = game_states[0];
  assign w_crash        = game_states[1];
  assign w_unused_flags = ^game_states[4:2];
  assign w_sum          = {1'b0, r_score} + {1'b0, BONUS_POINTS};

  always_comb begin
    w_state_d   = r_state;
    w_fcnt_d    = r_fcnt;
    w_visible_d = r_visible;
    w_pulse_d   = 1'b0;
    if (r_frame_tick) begin
      unique case (r_state)
        StPlay: begin
          if (w_crash) begin
            w_state_d = StCrash;
            w_fcnt_d  = CrashLoad;
          end else if (w_bonus) begin
            w_state_d   = StHide;
            w_fcnt_d    = HideLoad;
            w_visible_d = 1'b0;
            w_pulse_d   = 1'b1;
          end
        end
        StHide: begin
          // Bonus stays hidden through a crash until the recovery window ends.
          if (w_crash) begin
            w_state_d = StCrash;
            w_fcnt_d  = CrashLoad;
          end else if (r_fcnt == 8'd0) begin
            w_state_d   = StPlay;
            w_visible_d = 1'b1;
          end else begin
            w_fcnt_d = r_fcnt - 8'd1;
          end
        end
        StCrash: begin
          if (r_fcnt == 8'd0) begin
            w_state_d = StRecover;
            w_fcnt_d  = RecoverLoad;
          end else begin
            w_fcnt_d = r_fcnt - 8'd1;
          end
        end
        StRecover: begin
          if (r_fcnt == 8'd0) begin
            w_state_d   = StPlay;
            w_visible_d = 1'b1;
          end else begin
            w_fcnt_d = r_fcnt - 8'd1;
            if (w_bonus) begin
              w_visible_d = 1'b0;
              w_pulse_d   = 1'b1;
            end
          end
        end
        default: begin
          w_state_d = StPlay;
          w_fcnt_d  = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_score_d = r_score;
    if (score_clear) begin
      w_score_d = 16'd0;
    end else if (w_pulse_d) begin
      w_score_d = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StPlay;
      r_fcnt       <= 8'd0;
      r_frame_tick <= 1'b0;
      r_visible    <= 1'b1;
      r_pulse      <= 1'b0;
      r_freeze     <= 1'b0;
      r_blink      <= 1'b0;
      r_score      <= 16'd0;
    end else begin
      r_state      <= w_state_d;
      r_fcnt       <= w_fcnt_d;
      r_frame_tick <= startOfFrame;
      r_visible    <= w_visible_d;
      r_pulse      <= w_pulse_d;
      r_freeze     <= (w_state_d == StCrash);
      r_blink      <= (w_state_d == StRecover) && w_fcnt_d[2];
      r_score      <= w_score_d;
    end
  end

  assign bonus_pulse   = r_pulse;
  assign bonus_visible = r_visible;
  assign freeze        = r_freeze;
  assign player_blink  = r_blink;
  assign score         = r_score;
  assign fsm_state     = r_state;

endmodule

// File: tb/tb_collision_event_ctrl.sv
// Directed bench for collision_event_ctrl: a frame-level reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_collision_event_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        startOfFrame = 1'b0;
  logic [4:0]  game_states = 5'd0;
  logic        score_clear = 1'b0;
  logic        bonus_pulse, bonus_visible, freeze, player_blink;
  logic [15:0] score;
  logic [1:0]  fsm_state;

  collision_event_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .game_states  (game_states),
    .score_clear  (score_clear),
    .bonus_pulse  (bonus_pulse),
    .bonus_visible(bonus_visible),
    .freeze       (freeze),
    .player_blink (player_blink),
    .score        (score),
    .fsm_state    (fsm_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int npulse   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: modes 0 play, 1 hide, 2 crash, 3 recover; m_rem = frames left before exit.
  int m_state, m_rem, m_score;
  bit m_vis, m_pulse, m_tick;

  function automatic int frames_of(input int st);
    case (st)
      1:       return 60;
      2:       return 45;
      default: return 90;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = 0; m_rem = 0; m_score = 0; m_vis = 1; m_pulse = 0; m_tick = 0;
    end else begin
      bit b, c;
      b = game_states[0];
      c = game_states[1];
      m_pulse = 0;
      if (m_tick) begin
        if ((m_state == 0 || m_state == 1) && c) begin
          m_state = 2; m_rem = frames_of(2) - 1;
        end else if (m_state == 0) begin
          if (b) begin m_state = 1; m_rem = frames_of(1) - 1; m_vis = 0; m_pulse = 1; end
        end else if (m_rem == 0) begin
          if (m_state == 2) begin m_state = 3; m_rem = frames_of(3) - 1; end
          else begin m_state = 0; m_vis = 1; end
        end else begin
          m_rem--;
          if (m_state == 3 && b) begin m_vis = 0; m_pulse = 1; end
        end
      end
      if (score_clear) m_score = 0;
      else if (m_pulse) m_score = (m_score + 100 > 65535) ? 65535 : m_score + 100;
      m_tick = startOfFrame;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pulse",   32'(bonus_pulse),   32'(m_pulse));
      chk("visible", 32'(bonus_visible), 32'(m_vis));
      chk("freeze",  32'(freeze),        32'(m_state == 2));
      chk("blink",   32'(player_blink),  (m_state == 3) ? 32'((m_rem / 4) % 2) : 32'd0);
      chk("score",   32'(score),         32'(m_score));
      chk("state",   32'(fsm_state),     32'(m_state));
    end
    if (bonus_pulse) npulse++;
  end

  task automatic frame(input bit b, input bit c, input bit clr);
    @(negedge clk);
    startOfFrame = 1'b1;
    game_states  = {3'($urandom_range(0, 7)), c, b};
    @(negedge clk);
    startOfFrame = 1'b0;
    score_clear  = clr;
    @(negedge clk);
    score_clear  = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) frame(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int base, guard;
    #2 reset = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_state", 32'(fsm_state), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_vis",   32'(bonus_visible), 1);
    chk("rst_frz",   32'(freeze), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single bonus, 60-frame hide.
    base = npulse;
    frame(1'b1, 1'b0, 1'b0);
    chk("bonus_pulses", 32'(npulse - base), 1);
    chk("bonus_score", 32'(score), 100);
    chk("bonus_hidden", 32'(bonus_visible), 0);
    idle(59);
    chk("hide_59", 32'(fsm_state), 1);
    idle(1);
    chk("hide_exit", 32'(fsm_state), 0);
    chk("hide_exit_vis", 32'(bonus_visible), 1);

    // Held bonus counts once.
    base = npulse;
    repeat (10) frame(1'b1, 1'b0, 1'b0);
    chk("held_pulses", 32'(npulse - base), 1);
    chk("held_score", 32'(score), 200);
    idle(50);
    chk("held_hide", 32'(fsm_state), 1);
    idle(1);
    chk("held_exit", 32'(fsm_state), 0);

    // Bonus and crash together: crash wins.
    base = npulse;
    frame(1'b1, 1'b1, 1'b0);
    chk("both_state", 32'(fsm_state), 2);
    chk("both_freeze", 32'(freeze), 1);
    chk("both_score", 32'(score), 200);
    chk("both_nopulse", 32'(npulse - base), 0);
    idle(44);
    chk("crash_44", 32'(fsm_state), 2);
    idle(1);
    chk("recover_entry", 32'(fsm_state), 3);
    chk("recover_unfrz", 32'(freeze), 0);
    chk("blink_89", 32'(player_blink), 0);
    idle(2);
    chk("blink_87", 32'(player_blink), 1);
    frame(1'b1, 1'b0, 1'b0);
    chk("rec_bonus_score", 32'(score), 300);
    chk("rec_bonus_state", 32'(fsm_state), 3);
    chk("rec_bonus_vis", 32'(bonus_visible), 0);
    idle(86);
    chk("rec_last", 32'(fsm_state), 3);
    idle(1);
    chk("rec_exit", 32'(fsm_state), 0);
    chk("rec_exit_vis", 32'(bonus_visible), 1);

    // Crash in frame 5 of hide.
    frame(1'b1, 1'b0, 1'b0);
    chk("h5_score", 32'(score), 400);
    idle(3);
    frame(1'b0, 1'b1, 1'b0);
    chk("h5_crash", 32'(fsm_state), 2);
    chk("h5_vis", 32'(bonus_visible), 0);
    idle(44);
    chk("h5_crash_44", 32'(fsm_state), 2);
    idle(1);
    chk("h5_recover", 32'(fsm_state), 3);
    chk("h5_rec_vis", 32'(bonus_visible), 0);
    idle(89);
    chk("h5_rec_89", 32'(fsm_state), 3);
    idle(1);
    chk("h5_play", 32'(fsm_state), 0);
    chk("h5_play_vis", 32'(bonus_visible), 1);

    // Clear, then saturate using bonus frames inside recovery windows.
    @(negedge clk); score_clear = 1'b1;
    @(negedge clk); score_clear = 1'b0;
    chk("clear", 32'(score), 0);
    base = npulse; guard = 0;
    while ((npulse - base) < 655 && guard < 3000) begin frame(1'b1, 1'b1, 1'b0); guard++; end
    chk("sat_guard1", 32'(guard < 3000), 1);
    chk("sat_65500", 32'(score), 65500);
    guard = 0;
    while ((npulse - base) < 656 && guard < 300) begin frame(1'b1, 1'b1, 1'b0); guard++; end
    chk("sat_ffff", 32'(score), 32'hFFFF);
    guard = 0;
    while ((npulse - base) < 657 && guard < 300) begin frame(1'b1, 1'b1, 1'b0); guard++; end
    chk("sat_hold", 32'(score), 32'hFFFF);
    chk("sat_guard2", 32'(guard < 300), 1);

    // Clear beats a same-edge add.
    guard = 0;
    base = npulse;
    while (npulse == base && guard < 300) begin frame(1'b1, 1'b1, 1'b1); guard++; end
    chk("clr_vs_add", 32'(score), 0);
    chk("clr_guard", 32'(guard < 300), 1);

    // Asynchronous reset in the middle of a crash.
    guard = 0;
    while (fsm_state != 2'd0 && guard < 300) begin idle(1); guard++; end
    chk("to_play_guard", 32'(guard < 300), 1);
    frame(1'b1, 1'b0, 1'b0);
    frame(1'b0, 1'b1, 1'b0);
    idle(3);
    chk("pre_rst_state", 32'(fsm_state), 2);
    chk("pre_rst_score", 32'(score), 100);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_state", 32'(fsm_state), 0);
    chk("arst_freeze", 32'(freeze), 0);
    chk("arst_vis", 32'(bonus_visible), 1);
    chk("arst_score", 32'(score), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    frame(1'b1, 1'b0, 1'b0);
    chk("post_rst_score", 32'(score), 100);
    chk("post_rst_state", 32'(fsm_state), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
